// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812B strip driver.
package ws2812_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StLatch
  } state_e;

  // Default bit timing in cycles of a 40 MHz clock.
  localparam int unsigned DefT0hCyc = 16;
  localparam int unsigned DefT0lCyc = 34;
  localparam int unsigned DefT1hCyc = 32;
  localparam int unsigned DefT1lCyc = 18;
  localparam int unsigned DefResCyc = 3200;

  localparam int unsigned MaxLeds      = 64;
  localparam int unsigned BitsPerPixel = 24;

  // Colour word packing: G in [23:16], R in [15:8], B in [7:0]; G7 goes out first.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Select the colour bit for one pixel: foreground when the mask bit is set.
  function automatic logic grb_bit(input logic use_fg, input grb_t fg, input grb_t bg,
                                   input logic [4:0] idx);
    logic [BitsPerPixel-1:0] f;
    logic [BitsPerPixel-1:0] b;
    f = fg;
    b = bg;
    return use_fg ? f[idx] : b[idx];
  endfunction

endpackage

// File: rtl/ws2812_strip_driver_if.sv
// Controller-side handshake and pixel data bundle for the strip driver.
interface ws2812_strip_driver_if #(
  parameter int unsigned NumLeds = 12
);
  logic               start;
  logic [NumLeds-1:0] led_mask;
  logic [23:0]        fg_grb;
  logic [23:0]        bg_grb;
  logic               led_dout;
  logic               busy;
  logic               done;

  modport master (
    output start, led_mask, fg_grb, bg_grb,
    input  led_dout, busy, done
  );

  modport slave (
    input  start, led_mask, fg_grb, bg_grb,
    output led_dout, busy, done
  );
endinterface

// File: rtl/ws2812_bit_tx.sv
// Single-bit WS2812 symbol generator: a valid strobe launches one high phase then
// one low phase whose lengths depend on the bit value. A new strobe in the last low
// cycle chains the next bit with no gap.
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC = DefT0hCyc,
  parameter int unsigned T0L_CYC = DefT0lCyc,
  parameter int unsigned T1H_CYC = DefT1hCyc,
  parameter int unsigned T1L_CYC = DefT1lCyc
) (
  input  logic clk,
  input  logic res,
  input  logic valid_i,
  input  logic bit_i,
  output logic line_o,
  output logic high_end_o,
  output logic bit_done_o
);

  localparam int unsigned MaxCyc = max4(T0H_CYC, T0L_CYC, T1H_CYC, T1L_CYC);
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            line_q, line_d;
  logic            bit_q, bit_d;
  logic            active_q, active_d;
  logic            last_cyc;

  // Phase counter counts down to zero; zero marks the final cycle of a phase.
  assign last_cyc   = active_q && (cnt_q == '0);
  assign high_end_o = last_cyc && line_q;
  assign bit_done_o = last_cyc && !line_q;
  assign line_o     = line_q;

  // Next-state: load high phase on strobe, switch to low phase, then go quiet.
  always_comb begin
    cnt_d    = cnt_q;
    line_d   = line_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (valid_i) begin
      active_d = 1'b1;
      bit_d    = bit_i;
      line_d   = 1'b1;
      cnt_d    = bit_i ? CntW'(T1H_CYC - 1) : CntW'(T0H_CYC - 1);
    end else if (active_q) begin
      if (cnt_q == '0) begin
        if (line_q) begin
          line_d = 1'b0;
          cnt_d  = bit_q ? CntW'(T1L_CYC - 1) : CntW'(T0L_CYC - 1);
        end else begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Phase state registers; reset drops the line at once.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q    <= '0;
      line_q   <= 1'b0;
      bit_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812B chain driver: shadows mask and colours on start, streams NUM_LEDS*24 bits
// MSB first from LED 0, then holds the line low for the latch time and pulses done.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 12,
  parameter int unsigned T0H_CYC  = DefT0hCyc,
  parameter int unsigned T0L_CYC  = DefT0lCyc,
  parameter int unsigned T1H_CYC  = DefT1hCyc,
  parameter int unsigned T1L_CYC  = DefT1lCyc,
  parameter int unsigned RES_CYC  = DefResCyc
) (
  input logic                 clk,
  input logic                 res,
  ws2812_strip_driver_if.slave bus
);

  localparam int unsigned     LedW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned     LatW     = $clog2(RES_CYC + 1);
  localparam logic [LedW-1:0] LastLed  = LedW'(NUM_LEDS - 1);
  localparam logic [4:0]      FirstBit = 5'(BitsPerPixel - 1);

  if (NUM_LEDS < 1 || NUM_LEDS > MaxLeds) begin : g_bad_num_leds
    $error("ws2812_strip_driver: NUM_LEDS must be in 1..%0d", MaxLeds);
  end
  if (T0H_CYC == 0 || T0L_CYC == 0 || T1H_CYC == 0 || T1L_CYC == 0 || RES_CYC == 0)
  begin : g_bad_timing
    $error("ws2812_strip_driver: every timing parameter must be at least 1");
  end

  state_e                state_q, state_d;
  logic [NUM_LEDS-1:0]   mask_q, mask_d;
  logic [23:0]           fg_q, fg_d;
  logic [23:0]           bg_q, bg_d;
  logic [LedW-1:0]       led_idx_q, led_idx_d;
  logic [4:0]            bit_idx_q, bit_idx_d;
  logic [LatW-1:0]       latch_cnt_q, latch_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  tx_valid;
  logic                  tx_bit;
  logic                  tx_line;
  logic                  tx_high_end;
  logic                  tx_bit_done;

  logic                  last_bit;
  logic [LedW-1:0]       nxt_led;
  logic [4:0]            nxt_bit;

  ws2812_bit_tx #(
    .T0H_CYC(T0H_CYC),
    .T0L_CYC(T0L_CYC),
    .T1H_CYC(T1H_CYC),
    .T1L_CYC(T1L_CYC)
  ) u_bit_tx (
    .clk       (clk),
    .res       (res),
    .valid_i   (tx_valid),
    .bit_i     (tx_bit),
    .line_o    (tx_line),
    .high_end_o(tx_high_end),
    .bit_done_o(tx_bit_done)
  );

  // Position of the bit that follows the one currently on the line.
  always_comb begin
    last_bit = (led_idx_q == LastLed) && (bit_idx_q == '0);
    nxt_led  = (bit_idx_q == '0) ? led_idx_q + LedW'(1) : led_idx_q;
    nxt_bit  = (bit_idx_q == '0) ? FirstBit : bit_idx_q - 5'd1;
  end

  // Frame sequencer: accept, chain bits back to back, latch, signal done.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    led_idx_d   = led_idx_q;
    bit_idx_d   = bit_idx_q;
    latch_cnt_d = latch_cnt_q;
    done_d      = 1'b0;
    tx_valid    = 1'b0;
    tx_bit      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mask_d    = bus.led_mask;
          fg_d      = bus.fg_grb;
          bg_d      = bus.bg_grb;
          led_idx_d = '0;
          bit_idx_d = FirstBit;
          // First bit comes from the live inputs since the shadows load this edge.
          tx_valid  = 1'b1;
          tx_bit    = grb_bit(bus.led_mask[0], bus.fg_grb, bus.bg_grb, FirstBit);
          state_d   = StHigh;
        end
      end
      StHigh: begin
        if (tx_high_end) state_d = StLow;
      end
      StLow: begin
        if (tx_bit_done) begin
          if (last_bit) begin
            latch_cnt_d = LatW'(RES_CYC - 1);
            state_d     = StLatch;
          end else begin
            led_idx_d = nxt_led;
            bit_idx_d = nxt_bit;
            tx_valid  = 1'b1;
            tx_bit    = grb_bit(mask_q[nxt_led], fg_q, bg_q, nxt_bit);
            state_d   = StHigh;
          end
        end
      end
      StLatch: begin
        if (latch_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          latch_cnt_d = latch_cnt_q - LatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d != StIdle);

  // Sequencer state, shadows and registered status outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      led_idx_q   <= '0;
      bit_idx_q   <= '0;
      latch_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      led_idx_q   <= led_idx_d;
      bit_idx_q   <= bit_idx_d;
      latch_cnt_q <= latch_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.led_dout = tx_line;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
